instruction_decode_queue: RTL and testbench
===========================================

# instruction_decode_queue

Buffered, handshaked RV32/RV64 instruction decoder sitting between fetch and execute in the rapid core. Accepts fetched instruction/PC pairs into a DEPTH-entry FIFO, decodes the head into a registered output stage (class, register indices, sign-extended immediate, illegal flag), and holds it until execute accepts it. Replaces the single-slot state-machine decoder with a back-pressure-safe, flushable, width-generic queue.

## Interface
- XLEN, 32, datapath/PC/immediate width; 32 or 64 only.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  discard all buffered and output-stage instructions (branch redirect).
- i_valid  in  1  fetch offers i_instruction/i_pc.
- o_ready  out  1  FIFO can accept this cycle.
- i_instruction  in  32  raw instruction word.
- i_pc  in  XLEN  instruction address.
- o_valid  out  1  output stage holds a decoded instruction.
- i_ready  in  1  execute consumes output stage this cycle.
- o_pc  out  XLEN  PC of decoded instruction.
- o_imm  out  XLEN  sign-extended immediate.
- o_rd, o_rs1, o_rs2  out  5 each  register indices.
- o_funct3  out  3  funct3 field.
- o_op_class  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 FENCE, 10 SYSTEM, 11 MULDIV, 15 ILLEGAL.
- o_illegal  out  1  unsupported opcode/funct combination.
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy (output stage excluded).

## Operation
- Push: i_valid && o_ready writes {instruction, pc} at write pointer; pointers wrap modulo DEPTH.
- o_ready = (o_count < DEPTH) && !i_reset; a pop in the same cycle does not free space for a full-FIFO push.
- Output stage loads FIFO head when FIFO non-empty and (!o_valid || i_ready); pop and decode happen in that edge.
- o_valid drops when i_ready && o_valid and FIFO empty.
- Immediate formats: I (LOAD, OP_IMM, JALR, SYSTEM), S, B, U (imm[31:12]<<12), J; all sign-extended from instruction bit 31 to XLEN. OP, MULDIV, FENCE, ILLEGAL: o_imm = 0.
- o_rd/o_rs1/o_rs2/o_funct3 always copied from bit fields regardless of class.
- Illegal: opcode outside the listed classes, low two bits ≠ 2'b11, OP with funct7 ∉ {0x00, 0x20} (0x20 only with funct3 0 or 5), BRANCH funct3 2/3, LOAD funct3 3/6/7 (XLEN=32), STORE funct3 ≥3 (XLEN=32). Illegal → o_op_class 15, o_illegal 1, still presented with o_valid.
- Flush: clears FIFO pointers, o_count, o_valid; same-cycle push is dropped; flush beats everything except reset.

## Timing
- Reset: o_valid 0, o_count 0, o_ready 0 during reset and 1 the cycle after, o_pc/o_imm/o_rd/o_rs1/o_rs2/o_funct3 0, o_op_class 0, o_illegal 0.
- Latency: push at edge N, empty pipeline → o_valid high after edge N+1 (2 edges total).
- Throughput: 1 instruction/cycle sustained with i_valid and i_ready held high.
- Output fields stable while o_valid && !i_ready.
- Reset mid-operation: all buffered instructions lost, identical to flush plus output reset values.
- Capacity: DEPTH + 1 instructions (FIFO + output stage).

## Configuration
- DECODE_MULDIV_EN defined: OP with funct7 0x01 decodes as MULDIV (class 11), o_illegal 0.
- Undefined: same encoding → class 15, o_illegal 1; no other behaviour change.

## Test plan
- Reset then push 0x00500613 @ PC 0x20 → two edges later o_valid 1, class 7, rd 12, rs1 0, funct3 0, imm 0x00000005, o_pc 0x20.
- Push 0xffb00613 → o_imm 0xFFFFFFFB (XLEN=32), 0xFFFFFFFFFFFFFFFB (XLEN=64).
- Push 0xFE208EE3 (beq x1,x2,-4) → class 4, rs1 1, rs2 2, imm −4; push 0x00512423 (sw x5,8(x2)) → class 6, rs1 2, rs2 5, imm 8.
- Hold i_ready 0, push DEPTH+1 instructions → o_count = DEPTH, o_ready 0, output fields unchanged; release i_ready → instructions drain in order, one per cycle.
- Push 0x02C58533 → class 11/o_illegal 0 with DECODE_MULDIV_EN, class 15/o_illegal 1 without; push 0x00000000 → o_illegal 1 in both builds.
- Fill 3 entries, assert i_flush with i_valid high → next cycle o_count 0, o_valid 0, pushed instruction never appears.

Source files
------------

// File: rtl/instruction_decode_queue.sv
// instruction_decode_queue: FIFO-buffered RV32/RV64 decoder with a registered output stage; DECODE_MULDIV_EN enables MULDIV decode
module instruction_decode_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [2:0]      o_funct3,
  output logic [3:0]      o_op_class,
  output logic            o_illegal,
  output logic [CW-1:0]   o_count
);
`ifdef DECODE_MULDIV_EN
  localparam logic MULDIV_EN = 1'b1;
`else
  localparam logic MULDIV_EN = 1'b0;
`endif
  logic [31:0]     ins_mem [DEPTH];
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  logic [31:0]     ins;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic [3:0]      cls;
  logic            ld_bad, st_bad, op_ok;
  assign o_ready = (o_count < CW'(DEPTH)) && !i_reset;
  assign push    = i_valid && o_ready && !i_flush;
  assign pop     = (o_count != '0) && (!o_valid || i_ready) && !i_flush;
  assign ins   = ins_mem[rd_ptr];
  assign opc   = ins[6:0];
  assign f3    = ins[14:12];
  assign f7    = ins[31:25];
  assign imm_i = XLEN'($signed(ins[31:20]));
  assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
  assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({ins[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
  assign ld_bad = (XLEN == 32) ? (f3 == 3'd3 || f3[2:1] == 2'b11) : (f3 == 3'd7);
  assign st_bad = f3 > ((XLEN == 32) ? 3'd2 : 3'd3);
  assign op_ok  = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
  always_comb begin
    cls = 4'd15;
    imm = '0;
    case (opc)
      7'h37: begin cls = 4'd0; imm = imm_u; end
      7'h17: begin cls = 4'd1; imm = imm_u; end
      7'h6f: begin cls = 4'd2; imm = imm_j; end
      7'h67: begin cls = 4'd3; imm = imm_i; end
      7'h63: begin cls = (f3 == 3'd2 || f3 == 3'd3) ? 4'd15 : 4'd4; imm = imm_b; end
      7'h03: begin cls = ld_bad ? 4'd15 : 4'd5; imm = imm_i; end
      7'h23: begin cls = st_bad ? 4'd15 : 4'd6; imm = imm_s; end
      7'h13: begin cls = 4'd7; imm = imm_i; end
      7'h33: cls = op_ok ? 4'd8 : (MULDIV_EN && f7 == 7'h01) ? 4'd11 : 4'd15;
      7'h0f: cls = 4'd9;
      7'h73: begin cls = 4'd10; imm = imm_i; end
      default: ;
    endcase
    if (cls == 4'd15) imm = '0;
  end
  always_ff @(posedge i_clk)
    if (push) begin
      ins_mem[wr_ptr] <= i_instruction;
      pc_mem[wr_ptr]  <= i_pc;
    end
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
      o_valid <= 1'b0;
    end else begin
      wr_ptr  <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr  <= pop ? rd_ptr + AW'(1) : rd_ptr;
      o_count <= o_count + CW'(push) - CW'(pop);
      o_valid <= pop ? 1'b1 : (i_ready ? 1'b0 : o_valid);
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_pc       <= '0;
      o_imm      <= '0;
      o_rd       <= '0;
      o_rs1      <= '0;
      o_rs2      <= '0;
      o_funct3   <= '0;
      o_op_class <= '0;
      o_illegal  <= 1'b0;
    end else if (pop) begin
      o_pc       <= pc_mem[rd_ptr];
      o_imm      <= imm;
      o_rd       <= ins[11:7];
      o_rs1      <= ins[19:15];
      o_rs2      <= ins[24:20];
      o_funct3   <= f3;
      o_op_class <= cls;
      o_illegal  <= cls == 4'd15;
    end
  end
endmodule

// File: tb/tb_instruction_decode_queue.sv
// tb_instruction_decode_queue: directed self-checking bench for instruction_decode_queue (XLEN=32, DEPTH=4)
module tb_instruction_decode_queue;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  logic            i_clk = 1'b0;
  logic            i_reset, i_flush, i_valid, i_ready;
  logic            o_ready, o_valid, o_illegal;
  logic [31:0]     i_instruction;
  logic [XLEN-1:0] i_pc, o_pc, o_imm;
  logic [4:0]      o_rd, o_rs1, o_rs2;
  logic [2:0]      o_funct3;
  logic [3:0]      o_op_class;
  logic [CW-1:0]   o_count;
  int checks = 0;
  int failures = 0;
  instruction_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_instruction(i_instruction), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_imm(o_imm), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
    .o_funct3(o_funct3), .o_op_class(o_op_class), .o_illegal(o_illegal), .o_count(o_count)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    i_valid = 1'b1;
    i_instruction = ins;
    i_pc = pc;
    step();
    i_valid = 1'b0;
    step();
  endtask
  task automatic take();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask
  function automatic logic [31:0] addi_k(input int k);
    addi_k = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction
  initial begin
    i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_instruction = '0; i_pc = '0;
    step(); step();
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_class", o_op_class, 0);
    check("rst_imm", o_imm, 0);
    check("rst_illegal", o_illegal, 0);
    i_reset = 1'b0;
    #1;
    check("ready_after_rst", o_ready, 1);
    i_valid = 1'b1; i_instruction = 32'h00500613; i_pc = 32'h20;
    step();
    i_valid = 1'b0;
    check("lat_valid_n", o_valid, 0);
    check("lat_count_n", o_count, 1);
    step();
    check("lat_valid_n1", o_valid, 1);
    check("addi_class", o_op_class, 7);
    check("addi_rd", o_rd, 12);
    check("addi_rs1", o_rs1, 0);
    check("addi_f3", o_funct3, 0);
    check("addi_imm", o_imm, 5);
    check("addi_pc", o_pc, 32'h20);
    check("addi_count", o_count, 0);
    take();
    check("drop_valid", o_valid, 0);
    send(32'hffb00613, 32'h24);
    check("neg_imm", o_imm, 32'hFFFFFFFB);
    take();
    send(32'hFE208EE3, 32'h28);
    check("beq_class", o_op_class, 4);
    check("beq_rs1", o_rs1, 1);
    check("beq_rs2", o_rs2, 2);
    check("beq_imm", o_imm, 32'hFFFFFFFC);
    take();
    send(32'h00512423, 32'h2c);
    check("sw_class", o_op_class, 6);
    check("sw_rs1", o_rs1, 2);
    check("sw_rs2", o_rs2, 5);
    check("sw_imm", o_imm, 8);
    check("sw_f3", o_funct3, 2);
    take();
    send(32'h123452B7, 32'h30);
    check("lui_class", o_op_class, 0);
    check("lui_imm", o_imm, 32'h12345000);
    check("lui_rd", o_rd, 5);
    take();
    send(32'h008000EF, 32'h34);
    check("jal_class", o_op_class, 2);
    check("jal_imm", o_imm, 8);
    take();
    send(32'h40B50533, 32'h38);
    check("sub_class", o_op_class, 8);
    check("sub_illegal", o_illegal, 0);
    check("sub_imm", o_imm, 0);
    take();
    send(32'h02C58533, 32'h3c);
`ifdef DECODE_MULDIV_EN
    check("mul_class", o_op_class, 11);
    check("mul_illegal", o_illegal, 0);
`else
    check("mul_class", o_op_class, 15);
    check("mul_illegal", o_illegal, 1);
`endif
    take();
    send(32'h00000000, 32'h40);
    check("zero_illegal", o_illegal, 1);
    check("zero_class", o_op_class, 15);
    check("zero_valid", o_valid, 1);
    take();
    send(32'h0000B003, 32'h44);
    check("ld_rv32_illegal", o_illegal, 1);
    take();
    // Back-pressure: five accepted, sixth refused while full
    i_valid = 1'b1;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      i_instruction = addi_k(k);
      i_pc = 32'h100 + 32'(4 * k);
      step();
    end
    i_instruction = addi_k(9);
    i_pc = 32'h200;
    check("full_count", o_count, DEPTH);
    check("full_ready", o_ready, 0);
    check("full_head_pc", o_pc, 32'h104);
    step();
    check("full_hold_rd", o_rd, 1);
    check("full_hold_imm", o_imm, 1);
    check("full_hold_count", o_count, DEPTH);
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 2; k <= DEPTH + 1; k++) begin
      step();
      check("drain_rd", o_rd, k);
      check("drain_pc", o_pc, 32'h100 + 32'(4 * k));
      check("drain_valid", o_valid, 1);
    end
    step();
    check("drain_end_valid", o_valid, 0);
    check("drain_end_count", o_count, 0);
    i_ready = 1'b0;
    // Flush with a simultaneous push
    i_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_instruction = addi_k(k);
      i_pc = 32'h300 + 32'(4 * k);
      step();
    end
    check("pre_flush_count", o_count, 3);
    i_flush = 1'b1;
    i_instruction = addi_k(20);
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush_count", o_count, 0);
    check("flush_valid", o_valid, 0);
    step();
    check("flush_drop_valid", o_valid, 0);
    check("flush_drop_count", o_count, 0);
    // Streaming throughput
    i_ready = 1'b1;
    i_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_instruction = addi_k(k);
      i_pc = 32'h400 + 32'(4 * k);
      step();
      if (k > 1) begin
        check("stream_valid", o_valid, 1);
        check("stream_rd", o_rd, k - 1);
      end
    end
    i_valid = 1'b0;
    step();
    check("stream_last_rd", o_rd, 4);
    check("stream_last_valid", o_valid, 1);
    step();
    check("stream_end_valid", o_valid, 0);
    i_ready = 1'b0;
    // Reset mid-operation
    i_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      i_instruction = addi_k(k + 5);
      step();
    end
    i_valid = 1'b0;
    i_reset = 1'b1;
    step();
    check("midrst_valid", o_valid, 0);
    check("midrst_count", o_count, 0);
    check("midrst_rd", o_rd, 0);
    check("midrst_imm", o_imm, 0);
    check("midrst_ready", o_ready, 0);
    i_reset = 1'b0;
    step();
    check("post_rst_ready", o_ready, 1);
    check("post_rst_valid", o_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
